// File: rtl/gray_chk_pkg.sv
// Shared types and defaults for the Gray-code step checker and related decode stages.
package gray_chk_pkg;

  typedef enum logic [1:0] {
    UNSYNC = 2'd0,
    TRACK  = 2'd1,
    FAULT  = 2'd2
  } state_e;

  localparam int GRAY_WIDTH_DEF = 3;
  localparam int ERR_CNT_W_DEF  = 8;
  localparam int RESYNC_LEN_DEF = 4;
  localparam int GRAY_MAX_W     = 16;

  // Fixed-max-width decode for contexts that cannot instantiate gray2bin_dec.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_dec.sv
// Combinational Gray-to-binary decoder; each binary bit is the XOR of all Gray bits at or above it.
module gray2bin_dec #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin[i] = ^gray[WIDTH-1:i];
  end

endmodule

// File: rtl/gray_step_checker.sv
// Checks a Gray counter's output against its enable, one step per sample; locks, tracks and re-locks.
module gray_step_checker
  import gray_chk_pkg::*;
#(
  parameter int WIDTH      = GRAY_WIDTH_DEF,
  parameter int ERR_CNT_W  = ERR_CNT_W_DEF,
  parameter int RESYNC_LEN = RESYNC_LEN_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [WIDTH-1:0]     gray_in,
  input  logic                 clear,
  output logic [WIDTH-1:0]     bin_out,
  output logic                 step_ok,
  output logic                 err_pulse,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 wrap_pulse,
  output logic [1:0]           state
);

  localparam int GR_W = (RESYNC_LEN > 1) ? $clog2(RESYNC_LEN) : 1;

  state_e           state_q;
  logic [WIDTH-1:0] bin_cur;
  logic [WIDTH-1:0] ref_bin;
  logic [WIDTH-1:0] exp_bin;
  logic             en_d;
  logic             match;
  logic [GR_W-1:0]  good_run;

  gray2bin_dec #(.WIDTH(WIDTH)) u_dec (
    .gray (gray_in),
    .bin  (bin_cur)
  );

  // The counter moves one edge after en, so the sample now reflects last cycle's enable.
  assign exp_bin = ref_bin + {{(WIDTH-1){1'b0}}, en_d};
  assign match   = (bin_cur == exp_bin);
  assign state   = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= UNSYNC;
      bin_out    <= '0;
      ref_bin    <= '0;
      en_d       <= 1'b0;
      good_run   <= '0;
      step_ok    <= 1'b0;
      err_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
      err_sticky <= 1'b0;
      err_count  <= '0;
    end else begin
      // Reference always reloads so a single fault is counted once.
      bin_out <= bin_cur;
      ref_bin <= bin_cur;
      en_d    <= en;
      if (clear) begin
        state_q    <= UNSYNC;
        good_run   <= '0;
        step_ok    <= 1'b0;
        err_pulse  <= 1'b0;
        wrap_pulse <= 1'b0;
        err_sticky <= 1'b0;
        err_count  <= '0;
      end else begin
        step_ok    <= 1'b0;
        err_pulse  <= 1'b0;
        wrap_pulse <= 1'b0;
        case (state_q)
          UNSYNC: state_q <= TRACK;
          TRACK, FAULT: begin
            if (match) begin
              if (en_d) begin
                step_ok    <= 1'b1;
                wrap_pulse <= (&ref_bin) && (bin_cur == '0);
              end
              if (state_q == FAULT) begin
                if (good_run == GR_W'(RESYNC_LEN-1)) begin
                  state_q  <= TRACK;
                  good_run <= '0;
                end else begin
                  good_run <= good_run + 1'b1;
                end
              end
            end else begin
              err_pulse  <= 1'b1;
              err_sticky <= 1'b1;
              if (err_count != '1) err_count <= err_count + 1'b1;
              good_run   <= '0;
              state_q    <= FAULT;
            end
          end
          default: state_q <= UNSYNC;
        endcase
      end
    end
  end

endmodule
